// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types, default vectors and priority encoder for the vectored interrupt controller
package intc_pkg;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam int INTC_VEC_BASE   = 'h3F0;
  localparam int INTC_VEC_STRIDE = 4;
  localparam int FF_W            = 16;

  // Lowest set index wins (channel 0 is highest priority); returns 0 for an empty vector.
  function automatic logic [3:0] find_first(input logic [FF_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = FF_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intc_timer.sv
// rtl/intc_timer.sv - periodic down-counter emitting a one-cycle tick every tmr_period clocks
module intc_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tmr_we,
  input  logic [TMR_W-1:0] tmr_period,
  output logic             tick
);

  logic [TMR_W-1:0] r_period;
  logic [TMR_W-1:0] r_cnt;

  assign tick = (r_cnt == '0) && (r_period != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (tmr_we) begin
      r_period <= tmr_period;
      r_cnt    <= tmr_period - TMR_W'(1);
    end else if (tick) begin
      r_cnt <= r_period - TMR_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

endmodule

// File: rtl/intc_vec.sv
// rtl/intc_vec.sv - vectored, nesting interrupt controller with edge capture, mask and periodic timer source
module intc_vec
  import intc_pkg::*;
#(
  parameter int              N_IRQ      = 4,
  parameter int              PC_W       = 10,
  parameter int              TMR_W      = 16,
  parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(INTC_VEC_BASE),
  parameter int              VEC_STRIDE = INTC_VEC_STRIDE,
  parameter int              TMR_CH     = N_IRQ - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IRQ-1:0]         irq_in,
  input  logic                     mask_we,
  input  logic [N_IRQ-1:0]         mask_wd,
  input  logic                     vec_we,
  input  logic [$clog2(N_IRQ)-1:0] vec_sel,
  input  logic [PC_W-1:0]          vec_wd,
  input  logic                     tmr_we,
  input  logic [TMR_W-1:0]         tmr_period,
  input  logic                     int_ack,
  input  logic                     int_ret,
  output logic                     int_req,
  output logic [PC_W-1:0]          int_vec,
  output logic [$clog2(N_IRQ)-1:0] int_id,
  output logic [N_IRQ-1:0]         in_service
);

  localparam int ID_W = $clog2(N_IRQ);

  state_t           r_state, w_next;
  logic             r_armed;
  logic [N_IRQ-1:0] r_irq_q, r_pending, r_mask, r_isr;
  logic [PC_W-1:0]  r_vec_tbl [N_IRQ];
  logic [ID_W-1:0]  r_id;
  logic [PC_W-1:0]  r_vec;

  logic             w_tick, w_issue, w_ack;
  logic [3:0]       w_isr_top;
  logic [ID_W-1:0]  w_sel_id;
  logic [N_IRQ-1:0] w_edge, w_prio, w_elig, w_ack_bit, w_ret_bit;

  intc_timer #(.TMR_W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tmr_we     (tmr_we),
    .tmr_period (tmr_period),
    .tick       (w_tick)
  );

  // r_armed masks the first cycle after reset so a level already high is not seen as an edge.
  assign w_edge    = ((irq_in & ~r_irq_q) & {N_IRQ{r_armed}})
                   | ({{(N_IRQ-1){1'b0}}, w_tick} << TMR_CH);
  assign w_isr_top = find_first(FF_W'(r_isr));
  assign w_prio    = (r_isr == '0) ? '1 : ((N_IRQ'(1) << w_isr_top) - N_IRQ'(1));
  assign w_elig    = r_pending & r_mask & w_prio;
  assign w_sel_id  = ID_W'(find_first(FF_W'(w_elig)));
  assign w_ack     = (r_state == REQ) && int_ack;
  assign w_ack_bit = w_ack ? (N_IRQ'(1) << r_id) : '0;
  assign w_ret_bit = (int_ret && (r_isr != '0)) ? (N_IRQ'(1) << w_isr_top) : '0;

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_elig != '0) begin
          w_next  = REQ;
          w_issue = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_armed   <= 1'b0;
      r_irq_q   <= '0;
      r_pending <= '0;
      r_isr     <= '0;
      r_mask    <= '0;
      r_id      <= '0;
      r_vec     <= '0;
      for (int i = 0; i < N_IRQ; i++) begin
        r_vec_tbl[i] <= PC_W'(int'(VEC_BASE) + i * VEC_STRIDE);
      end
    end else begin
      r_armed   <= 1'b1;
      r_irq_q   <= irq_in;
      r_pending <= (r_pending & ~w_ack_bit) | w_edge;
      // Return clears the innermost level before an ack in the same cycle opens a new one.
      r_isr     <= (r_isr & ~w_ret_bit) | w_ack_bit;
      if (mask_we) r_mask <= mask_wd;
      if (vec_we && (int'(vec_sel) < N_IRQ)) r_vec_tbl[vec_sel] <= vec_wd;
      if (w_issue) begin
        r_id  <= w_sel_id;
        r_vec <= r_vec_tbl[w_sel_id];
      end
    end
  end

  assign int_req    = (r_state == REQ);
  assign int_id     = r_id;
  assign int_vec    = r_vec;
  assign in_service = r_isr;

endmodule

// File: tb/tb_intc_vec.sv
// tb/tb_intc_vec.sv - directed self-checking bench for intc_vec
module tb_intc_vec;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic       vec_we;
  logic [1:0] vec_sel;
  logic [9:0] vec_wd;
  logic       tmr_we;
  logic [15:0] tmr_period;
  logic       int_ack;
  logic       int_ret;
  logic       int_req;
  logic [9:0] int_vec;
  logic [1:0] int_id;
  logic [3:0] in_service;

  int tests_run = 0;
  int tests_failed = 0;

  intc_vec dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .vec_we     (vec_we),
    .vec_sel    (vec_sel),
    .vec_wd     (vec_wd),
    .tmr_we     (tmr_we),
    .tmr_period (tmr_period),
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; irq_in = '0; mask_we = 0; mask_wd = '0; vec_we = 0; vec_sel = '0;
    vec_wd = '0; tmr_we = 0; tmr_period = '0; int_ack = 0; int_ret = 0;
    cyc(3);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0b want 0", int_req); end
    tests_run++; if (int_id !== 2'd0) begin tests_failed++; $display("FAIL reset_id: got %0d want 0", int_id); end
    tests_run++; if (int_vec !== 10'h000) begin tests_failed++; $display("FAIL reset_vec: got %h want 000", int_vec); end
    tests_run++; if (in_service !== 4'b0000) begin tests_failed++; $display("FAIL reset_isr: got %b want 0000", in_service); end
    reset = 1'b1;
    cyc(2);
    int_ack = 1; cyc(1); int_ack = 0;
    tests_run++; if (in_service !== 4'b0000) begin tests_failed++; $display("FAIL idle_ack_isr: got %b want 0000", in_service); end
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL idle_ack_req: got %0b want 0", int_req); end
  endtask

  task automatic test_basic;
    mask_we = 1; mask_wd = 4'b1111; cyc(1); mask_we = 0;
    irq_in = 4'b0100; cyc(1);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL basic_early: got %0b want 0", int_req); end
    cyc(1);
    tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL basic_req: got %0b want 1", int_req); end
    tests_run++; if (int_id !== 2'd2) begin tests_failed++; $display("FAIL basic_id: got %0d want 2", int_id); end
    tests_run++; if (int_vec !== 10'h3F8) begin tests_failed++; $display("FAIL basic_vec: got %h want 3f8", int_vec); end
    irq_in = '0;
    int_ack = 1; cyc(1); int_ack = 0;
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL basic_ack_req: got %0b want 0", int_req); end
    tests_run++; if (in_service !== 4'b0100) begin tests_failed++; $display("FAIL basic_isr: got %b want 0100", in_service); end
    int_ret = 1; cyc(1); int_ret = 0;
    tests_run++; if (in_service !== 4'b0000) begin tests_failed++; $display("FAIL basic_ret: got %b want 0000", in_service); end
  endtask

  task automatic test_priority;
    irq_in = 4'b1010; cyc(2);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd1) begin tests_failed++; $display("FAIL prio_first: got req=%0b id=%0d want req=1 id=1", int_req, int_id); end
    tests_run++; if (int_vec !== 10'h3F4) begin tests_failed++; $display("FAIL prio_vec1: got %h want 3f4", int_vec); end
    irq_in = '0;
    int_ack = 1; cyc(1); int_ack = 0;
    cyc(1);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL prio_blocked: got %0b want 0", int_req); end
    int_ret = 1; cyc(1); int_ret = 0;
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL prio_ret_req: got %0b want 0", int_req); end
    cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd3) begin tests_failed++; $display("FAIL prio_second: got req=%0b id=%0d want req=1 id=3", int_req, int_id); end
    tests_run++; if (int_vec !== 10'h3FC) begin tests_failed++; $display("FAIL prio_vec3: got %h want 3fc", int_vec); end
    int_ack = 1; cyc(1); int_ack = 0;
    int_ret = 1; cyc(1); int_ret = 0;
  endtask

  task automatic test_nesting;
    irq_in = 4'b0100; cyc(1); irq_in = '0; cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd2) begin tests_failed++; $display("FAIL nest_ch2: got req=%0b id=%0d want req=1 id=2", int_req, int_id); end
    int_ack = 1; cyc(1); int_ack = 0;
    irq_in = 4'b0001; cyc(1); irq_in = '0; cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd0) begin tests_failed++; $display("FAIL nest_ch0: got req=%0b id=%0d want req=1 id=0", int_req, int_id); end
    tests_run++; if (int_vec !== 10'h3F0) begin tests_failed++; $display("FAIL nest_vec0: got %h want 3f0", int_vec); end
    int_ack = 1; int_ret = 1; cyc(1); int_ack = 0; int_ret = 0;
    tests_run++; if (in_service !== 4'b0001) begin tests_failed++; $display("FAIL nest_ack_ret: got %b want 0001", in_service); end
    irq_in = 4'b1000; cyc(1); irq_in = '0; cyc(2);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL nest_ch3_blocked: got %0b want 0", int_req); end
    int_ret = 1; cyc(1); int_ret = 0;
    tests_run++; if (in_service !== 4'b0000) begin tests_failed++; $display("FAIL nest_ret_isr: got %b want 0000", in_service); end
    cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd3) begin tests_failed++; $display("FAIL nest_ch3: got req=%0b id=%0d want req=1 id=3", int_req, int_id); end
    int_ack = 1; cyc(1); int_ack = 0;
    int_ret = 1; cyc(1); int_ret = 0;
  endtask

  task automatic test_vec_mask;
    vec_we = 1; vec_sel = 2'd1; vec_wd = 10'h120; mask_we = 1; mask_wd = 4'b0010; cyc(1);
    vec_we = 0; mask_we = 0;
    irq_in = 4'b0010; cyc(1); irq_in = '0; cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_vec !== 10'h120) begin tests_failed++; $display("FAIL vm_vec: got req=%0b vec=%h want req=1 vec=120", int_req, int_vec); end
    vec_we = 1; vec_sel = 2'd1; vec_wd = 10'h055; cyc(1); vec_we = 0;
    tests_run++; if (int_vec !== 10'h120) begin tests_failed++; $display("FAIL vm_frozen: got %h want 120", int_vec); end
    int_ack = 1; cyc(1); int_ack = 0;
    int_ret = 1; cyc(1); int_ret = 0;
    mask_we = 1; mask_wd = 4'b0000; cyc(1); mask_we = 0;
    irq_in = 4'b0010; cyc(1); irq_in = '0; cyc(2);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL vm_masked: got %0b want 0", int_req); end
    mask_we = 1; mask_wd = 4'b0010; cyc(1); mask_we = 0;
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL vm_unmask_early: got %0b want 0", int_req); end
    cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_vec !== 10'h055) begin tests_failed++; $display("FAIL vm_kept_pending: got req=%0b vec=%h want req=1 vec=055", int_req, int_vec); end
    int_ack = 1; cyc(1); int_ack = 0;
    int_ret = 1; cyc(1); int_ret = 0;
  endtask

  task automatic test_timer;
    mask_we = 1; mask_wd = 4'b1000; cyc(1); mask_we = 0;
    tmr_we = 1; tmr_period = 16'd5; cyc(1); tmr_we = 0;
    cyc(5);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL tmr_early1: got %0b want 0", int_req); end
    cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd3) begin tests_failed++; $display("FAIL tmr_tick1: got req=%0b id=%0d want req=1 id=3", int_req, int_id); end
    int_ack = 1; cyc(1); int_ack = 0;
    tests_run++; if (in_service !== 4'b1000) begin tests_failed++; $display("FAIL tmr_isr: got %b want 1000", in_service); end
    int_ret = 1; cyc(1); int_ret = 0;
    cyc(2);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL tmr_early2: got %0b want 0", int_req); end
    cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd3) begin tests_failed++; $display("FAIL tmr_tick2: got req=%0b id=%0d want req=1 id=3", int_req, int_id); end
    int_ack = 1; cyc(1); int_ack = 0;
    int_ret = 1; cyc(1); int_ret = 0;
    tmr_we = 1; tmr_period = 16'd0; cyc(1); tmr_we = 0;
    cyc(12);
    tests_run++; if (int_req !== 1'b0 || in_service !== 4'b0000) begin tests_failed++; $display("FAIL tmr_off: got req=%0b isr=%b want req=0 isr=0000", int_req, in_service); end
  endtask

  task automatic test_reset_in_req;
    mask_we = 1; mask_wd = 4'b1111; vec_we = 1; vec_sel = 2'd0; vec_wd = 10'h0AA; cyc(1);
    mask_we = 0; vec_we = 0;
    irq_in = 4'b0001; cyc(1); irq_in = '0; cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_vec !== 10'h0AA) begin tests_failed++; $display("FAIL rr_pre: got req=%0b vec=%h want req=1 vec=0aa", int_req, int_vec); end
    reset = 1'b0; irq_in = 4'b0010; cyc(1);
    tests_run++; if (int_req !== 1'b0 || int_vec !== 10'h000) begin tests_failed++; $display("FAIL rr_clear: got req=%0b vec=%h want req=0 vec=000", int_req, int_vec); end
    tests_run++; if (in_service !== 4'b0000) begin tests_failed++; $display("FAIL rr_isr: got %b want 0000", in_service); end
    cyc(1); reset = 1'b1; cyc(1);
    mask_we = 1; mask_wd = 4'b1111; cyc(1); mask_we = 0;
    cyc(3);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL rr_no_stale: got %0b want 0", int_req); end
    irq_in = 4'b0011; cyc(1); irq_in = 4'b0010; cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd0 || int_vec !== 10'h3F0) begin tests_failed++; $display("FAIL rr_vec_reset: got req=%0b id=%0d vec=%h want req=1 id=0 vec=3f0", int_req, int_id, int_vec); end
    int_ack = 1; cyc(1); int_ack = 0;
    int_ret = 1; cyc(1); int_ret = 0;
    irq_in = '0; cyc(1); irq_in = 4'b0010; cyc(1); irq_in = '0; cyc(1);
    tests_run++; if (int_req !== 1'b1 || int_id !== 2'd1 || int_vec !== 10'h3F4) begin tests_failed++; $display("FAIL rr_rearm: got req=%0b id=%0d vec=%h want req=1 id=1 vec=3f4", int_req, int_id, int_vec); end
    int_ack = 1; cyc(1); int_ack = 0;
    int_ret = 1; cyc(1); int_ret = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_nesting();
    test_vec_mask();
    test_timer();
    test_reset_in_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
